// File: rtl/int_regfile_wr_arb.sv
// Integer register file with one arbitrated write port shared by num_ports producers and two read ports.
// Optional build macro RF_ARB_FIXED_PRIO_EN swaps round-robin arbitration for fixed lowest-index priority.

module int_regfile_wr_arb #(
    parameter int data_width    = 32,
    parameter int num_regs      = 32,
    parameter int num_ports     = 3,
    parameter int reg_sel_width = $clog2(num_regs),
    parameter int port_width    = (num_ports > 1) ? $clog2(num_ports) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [num_ports-1:0]               wr_req,
    input  logic [num_ports*reg_sel_width-1:0] wr_sel,
    input  logic [num_ports*data_width-1:0]    wr_data,
    output logic [num_ports-1:0]               wr_ack,
    input  logic [reg_sel_width-1:0]           rd_sel_a,
    output logic [data_width-1:0]              rd_data_a,
    input  logic [reg_sel_width-1:0]           rd_sel_b,
    output logic [data_width-1:0]              rd_data_b
);

    logic [data_width-1:0]    regs_q [num_regs];
    logic [num_ports-1:0]     ack_q;
    logic [num_ports-1:0]     ack_d;
    logic [num_ports-1:0]     elig_s;
    logic                     grant_s;
    logic [port_width-1:0]    grant_idx_s;
    logic [reg_sel_width-1:0] grant_sel_s;
    logic [data_width-1:0]    grant_data_s;
`ifndef RF_ARB_FIXED_PRIO_EN
    logic [port_width-1:0]    rr_ptr_q;
    logic [port_width-1:0]    rr_ptr_d;
    int                       scan_s;
`endif

    // Grant selection; a port with its ack high is still holding a serviced request.
    always_comb begin
        elig_s      = wr_req & ~ack_q;
        grant_s     = 1'b0;
        grant_idx_s = {port_width{1'b0}};
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = num_ports - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                grant_s     = 1'b1;
                grant_idx_s = port_width'(i);
            end else begin
                grant_s     = grant_s;
            end
        end
`else
        scan_s = 0;
        for (int i = 0; i < num_ports; i++) begin
            scan_s = int'(rr_ptr_q) + i;
            if (scan_s >= num_ports) begin
                scan_s = scan_s - num_ports;
            end else begin
                scan_s = scan_s;
            end
            if (!grant_s && elig_s[scan_s]) begin
                grant_s     = 1'b1;
                grant_idx_s = port_width'(scan_s);
            end else begin
                grant_s     = grant_s;
            end
        end
`endif
    end

    // Mux out the granted port's destination and data, and build next-state ack/pointer.
    always_comb begin
        grant_sel_s  = wr_sel[grant_idx_s*reg_sel_width +: reg_sel_width];
        grant_data_s = wr_data[grant_idx_s*data_width +: data_width];
        ack_d        = {num_ports{1'b0}};
        if (grant_s) begin
            ack_d[grant_idx_s] = 1'b1;
        end else begin
            ack_d = {num_ports{1'b0}};
        end
`ifndef RF_ARB_FIXED_PRIO_EN
        if (!grant_s) begin
            rr_ptr_d = rr_ptr_q;
        end else if (grant_idx_s == port_width'(num_ports - 1)) begin
            rr_ptr_d = {port_width{1'b0}};
        end else begin
            rr_ptr_d = grant_idx_s + {{(port_width-1){1'b0}}, 1'b1};
        end
`endif
    end

    // State update: reset wins over any grant, so a request in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < num_regs; r++) begin
                regs_q[r] <= {data_width{1'b0}};
            end
            ack_q <= {num_ports{1'b0}};
`ifndef RF_ARB_FIXED_PRIO_EN
            rr_ptr_q <= {port_width{1'b0}};
`endif
        end else begin
            ack_q <= ack_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
            if (grant_s && (grant_sel_s != {reg_sel_width{1'b0}})) begin
                regs_q[grant_sel_s] <= grant_data_s;
            end
        end
    end

    assign wr_ack    = ack_q;
    assign rd_data_a = (rd_sel_a == {reg_sel_width{1'b0}}) ? {data_width{1'b0}} : regs_q[rd_sel_a];
    assign rd_data_b = (rd_sel_b == {reg_sel_width{1'b0}}) ? {data_width{1'b0}} : regs_q[rd_sel_b];

    int_regfile_wr_arb_chk #(
        .data_width    (data_width),
        .num_ports     (num_ports),
        .reg_sel_width (reg_sel_width)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .grant_s    (grant_s),
        .grant_sel  (grant_sel_s),
        .grant_data (grant_data_s)
    );

endmodule

// Known-value checks on the control inputs and on the payload of whichever port is granted.
module int_regfile_wr_arb_chk #(
    parameter int data_width    = 32,
    parameter int num_ports     = 3,
    parameter int reg_sel_width = 5
) (
    input logic                     clk,
    input logic                     rst,
    input logic [num_ports-1:0]     wr_req,
    input logic                     grant_s,
    input logic [reg_sel_width-1:0] grant_sel,
    input logic [data_width-1:0]    grant_data
);

    a_rst_known: assert property (@(posedge clk) !$isunknown(rst));
    a_req_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(wr_req));
    a_grant_known: assert property (@(posedge clk) disable iff (!rst)
        grant_s |-> !$isunknown({grant_sel, grant_data}));

endmodule

// File: tb/tb_int_regfile_wr_arb.sv
// Directed bench for int_regfile_wr_arb; expected acks go into a queue checked by a monitor.

module tb_int_regfile_wr_arb;

    localparam int DW = 32;
    localparam int NP = 3;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic [NP-1:0]    wr_req;
    logic [NP*SW-1:0] wr_sel;
    logic [NP*DW-1:0] wr_data;
    logic [NP-1:0]    wr_ack;
    logic [SW-1:0]    rd_sel_a;
    logic [DW-1:0]    rd_data_a;
    logic [SW-1:0]    rd_sel_b;
    logic [DW-1:0]    rd_data_b;

    int n_vec;
    int n_err;
    logic [NP-1:0] exp_q [$];
    logic [NP-1:0] ack_seen;

    int_regfile_wr_arb dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_sel_a  (rd_sel_a),
        .rd_data_a (rd_data_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_b (rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every nonzero ack must match the next expected grant, one cycle each.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_ack != 3'b000) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: got %b required none", wr_ack);
                end else begin
                    logic [NP-1:0] e;
                    e = exp_q.pop_front();
                    if (wr_ack !== e) begin
                        n_err++;
                        $display("FAIL ack_order: got %b required %b", wr_ack, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [SW-1:0] sel, input logic [DW-1:0] exp);
        rd_sel_a = sel;
        rd_sel_b = sel;
        #1;
        chk({nm, "_a"}, rd_data_a, exp);
        chk({nm, "_b"}, rd_data_b, exp);
    endtask

    // One clock; producers drop req once they have seen their ack during the previous cycle.
    task automatic tick();
        @(negedge clk);
        ack_seen = wr_ack;
        @(posedge clk);
        #1;
        wr_req = wr_req & ~ack_seen;
    endtask

    task automatic raise(input int p, input logic [SW-1:0] sel, input logic [DW-1:0] data);
        wr_req[p]            = 1'b1;
        wr_sel[p*SW +: SW]   = sel;
        wr_data[p*DW +: DW]  = data;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        wr_req   = 3'b000;
        wr_sel   = {(NP*SW){1'b0}};
        wr_data  = {(NP*DW){1'b0}};
        rd_sel_a = 5'd0;
        rd_sel_b = 5'd0;

        // Reset held with all ports requesting: no acks, everything reads zero.
        raise(0, 5'd1, 32'd11);
        raise(1, 5'd2, 32'd22);
        raise(2, 5'd3, 32'd33);
        tick();
        tick();
        rd("rst_r1", 5'd1, 32'd0);
        rd("rst_r3", 5'd3, 32'd0);
        wr_req = 3'b000;
        rst    = 1'b1;
        tick();
        rd("post_rst_r2", 5'd2, 32'd0);
        rd("post_rst_r31", 5'd31, 32'd0);

        // Three-way contention from pointer 0.
        raise(0, 5'd1, 32'd10);
        raise(1, 5'd2, 32'd20);
        raise(2, 5'd3, 32'd30);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        for (int i = 0; i < 4; i++) tick();
        rd("cont_r1", 5'd1, 32'd10);
        rd("cont_r2", 5'd2, 32'd20);
        rd("cont_r3", 5'd3, 32'd30);

        // Single write from port 1; old value visible until the committing edge.
        raise(1, 5'd5, 32'hDEADBEEF);
        exp_q.push_back(3'b010);
        rd("single_old", 5'd5, 32'd0);
        tick();
        rd("single_new", 5'd5, 32'hDEADBEEF);
        tick();
        tick();

        // Divider pattern: quotient then modulus from the same port.
        raise(1, 5'd7, 32'd3);
        exp_q.push_back(3'b010);
        tick();
        tick();
        raise(1, 5'd8, 32'd1);
        exp_q.push_back(3'b010);
        tick();
        tick();
        tick();
        rd("div_r7", 5'd7, 32'd3);
        rd("div_r8", 5'd8, 32'd1);

        // Write to x0 is acked but discarded.
        raise(2, 5'd0, 32'hFFFFFFFF);
        exp_q.push_back(3'b100);
        tick();
        tick();
        tick();
        rd("x0_read", 5'd0, 32'd0);
        rd("x0_r5_intact", 5'd5, 32'hDEADBEEF);

        // Reset arriving on the same edge as a request: no ack, no write.
        raise(0, 5'd4, 32'd99);
        rst = 1'b0;
        tick();
        wr_req = 3'b000;
        rst    = 1'b1;
        tick();
        tick();
        rd("midrst_r4", 5'd4, 32'd0);
        rd("midrst_r5", 5'd5, 32'd0);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_acks: got %0d outstanding required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_regfile_wr_arb.md
Name: int_regfile_wr_arb

Overview:
- Integer register file with a single arbitrated write port shared by several multi-cycle producers, plus two combinational read ports.
- Producers are the core writeback path and the int div unit; the int mul unit joins later.
- Each producer drives a req/sel/data triple and holds it until it sees a one-cycle ack.
- The block grants one write per cycle and returns that ack.
- Sits directly downstream of the divider's rf_wr_* interface.

Parameters:
- data_width, 32, bits per register and per write/read data bus
- num_regs, 32, number of architectural registers; register 0 reads as zero
- num_ports, 3, number of write requesters
- reg_sel_width, $clog2(num_regs), derived register selector width
- port_width, $clog2(num_ports) (min 1), derived width of the grant index

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low (0 = reset at posedge clk)
- wr_req  input  num_ports  per-port write request
- wr_sel  input  num_ports*reg_sel_width  per-port destination; port p in bits [p*reg_sel_width +: reg_sel_width]
- wr_data  input  num_ports*data_width  per-port write data; port p in bits [p*data_width +: data_width]
- wr_ack  output  num_ports  per-port registered one-cycle acknowledge
- rd_sel_a  input  reg_sel_width  read port A selector
- rd_data_a  output  data_width  read port A data, combinational
- rd_sel_b  input  reg_sel_width  read port B selector
- rd_data_b  output  data_width  read port B data, combinational

Behaviour:
- One clock domain (clk). rst is synchronous, active-low; all state changes on posedge clk only.
- Reset (rst==0 at posedge):
  - all registers cleared to 0
  - wr_ack = 0
  - round-robin pointer rr_ptr = 0
  - applies mid-operation: any pending or in-flight request is dropped, no write performed, no ack issued that cycle.
- Storage: regs[0..num_regs-1]. Register 0 is never written; rd_data for sel 0 is always 0.
- Reads:
  - rd_data_x = regs[rd_sel_x], purely combinational.
  - A write committed at edge N is visible on reads from cycle N onward (after the edge).
  - No same-cycle bypass unless stated otherwise.
- Eligibility: port p is eligible when wr_req[p]==1 and wr_ack[p]==0.
  - A port whose ack is currently high is ignored, because producers drive req from a register and only drop it the cycle after seeing ack. This prevents double-writes.
- Arbitration, evaluated combinationally each cycle:
  - Among eligible ports, grant the first found scanning rr_ptr, rr_ptr+1, ..., wrapping modulo num_ports.
  - At most one grant per cycle.
- At posedge with a grant g:
  - regs[wr_sel[g]] <= wr_data[g], skipped if wr_sel[g]==0.
  - wr_ack <= one-hot(g).
  - rr_ptr <= (g+1) mod num_ports, wrapping from num_ports-1 to 0.
- At posedge with no grant: wr_ack <= 0; rr_ptr unchanged.
- Latency: a request first sampled eligible at edge N with no contention is written at edge N, and wr_ack[p] is high during cycle N..N+1.
  - With k contending eligible ports, worst-case wait is num_ports-1 extra cycles.
- Ack is exactly one cycle wide per committed write, and is never asserted without a write or x0 discard.
- Back-to-back from one producer: req dropped during the ack cycle and then re-raised with a new sel/data in the following cycle is serviced as a new write. This is the div unit's quotient-then-modulus pattern.
- Simultaneous write and read of the same register in one cycle: read returns the old value.
- Write to register 0 is granted and acked normally; data is discarded.
- Unknowns: assert_known on rst, wr_req, and on wr_sel/wr_data of the granted port.

Optional Feature:
- Macro RF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index eligible port always wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- Eligibility and ack rules are identical in both modes.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_req=3'b111 -> no acks, all reads 0; release, then read any sel -> 0.
- Single write: port 1 req sel=5 data=32'hDEADBEEF -> wr_ack=3'b010 for exactly one cycle, rd_data_a(sel=5)=32'hDEADBEEF next cycle; req held during the ack cycle is not re-granted.
- Contention, round-robin: ports 0,1,2 all req with sels 1,2,3, data 10,20,30 -> acks in order 001,010,100 over three consecutive cycles, regs 1/2/3 = 10/20/30. With RF_ARB_FIXED_PRIO_EN and port 0 re-requesting immediately after its ack cycle, port 0 wins each contended cycle it is eligible.
- Divider pattern: port 1 quotient sel=7 data=3 -> ack; then sel=8 data=1 -> second ack; reg7=3, reg8=1, two acks total.
- x0 write: port 2 req sel=0 data=32'hFFFFFFFF -> ack issued, rd_data(sel=0) remains 0.
- Reset mid-operation: port 0 req sel=4 data=99, assert rst=0 at that same edge -> no ack, reg4=0 after release.
